// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// SERIAL_SUB_OVF_EN adds the signed-overflow flag.
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport slave (
        input  in_valid, a, b, bin, out_ready,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, diff, bout
    );

    modport master (
        output in_valid, a, b, bin, out_ready,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin, LSB first through one full-subtractor cell.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   s
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // S_INIT holds in_ready low for the first edge after reset release
    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_bout;
    logic             r_ovld;

    logic w_d;
    logic w_br_next;
    logic w_accept;
    logic w_last;
    logic w_cnt_bad;

    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_accept  = (r_state == S_IDLE) && s.in_valid;
    assign w_last    = (r_state == S_RUN) && (r_cnt == LAST);

    generate
        if ((2 ** CW) != WIDTH) begin : g_cnt_chk
            assign w_cnt_bad = (r_cnt > LAST);
        end else begin : g_cnt_full
            assign w_cnt_bad = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_diff  <= '0;
            r_br    <= 1'b0;
            r_bout  <= 1'b0;
            r_ovld  <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: r_state <= S_IDLE;
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= s.a;
                        r_b     <= s.b;
                        r_br    <= s.bin;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_cnt_bad) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_a    <= r_a >> 1;
                        r_b    <= r_b >> 1;
                        r_br   <= w_br_next;
                        r_diff <= {w_d, r_diff[WIDTH-1:1]};
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_ovld  <= 1'b1;
                            r_bout  <= w_br_next;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (s.out_ready) begin
                        r_ovld  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s.in_ready  = (r_state == S_IDLE);
    assign s.out_valid = r_ovld;
    assign s.diff      = r_diff;
    assign s.bout      = r_bout;

`ifdef SERIAL_SUB_OVF_EN
    // operand MSBs are kept because the shift registers lose them
    logic r_amsb;
    logic r_bmsb;
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_amsb <= s.a[WIDTH-1];
            r_bmsb <= s.b[WIDTH-1];
        end else if (w_last) begin
            r_ovf <= (r_amsb ^ r_bmsb) & (r_amsb ^ w_d);
        end
    end

    assign s.ovf = r_ovf;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, corner sequences, random vs arithmetic model.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor_if #(.WIDTH(W)) sif ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned and signed arithmetic
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int full;
        int sf;
        full = int'(a) - int'(b) - int'(bin);
        sf   = int'($signed(a)) - int'($signed(b)) - int'(bin);
        d    = full[W-1:0];
        bo   = (full < 0);
        ov   = (sf < -(2 ** (W-1))) || (sf > (2 ** (W-1)) - 1);
    endtask

    // Issue one operation, scramble inputs during RUN, apply backpressure, then check.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input logic [W-1:0] ed, input logic ebo,
                         input logic eov, input int hold);
        int           lat;
        int           wt;
        logic         stable;
        logic [W-1:0] d0;
        logic         bo0;
        wt = 0;
        @(negedge clk);
        while (!sif.in_ready && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        chk({tag, "_ready_wait"}, 32'(wt < 50), 32'd1);
        sif.in_valid = 1'b1;
        sif.a = a;
        sif.b = b;
        sif.bin = bin;
        @(posedge clk);
        #1;
        lat = 0;
        while (!sif.out_valid && lat < 100) begin
            sif.in_valid = 1'($urandom_range(0, 1));
            sif.a = W'($urandom);
            sif.b = W'($urandom);
            sif.bin = 1'($urandom_range(0, 1));
            sif.out_ready = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        sif.in_valid = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(W));
        d0 = sif.diff;
        bo0 = sif.bout;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (sif.diff !== d0 || sif.bout !== bo0 || sif.out_valid !== 1'b1 || sif.in_ready !== 1'b0)
                stable = 1'b0;
        end
        chk({tag, "_hold_stable"}, 32'(stable), 32'd1);
        chk({tag, "_diff"}, 32'(sif.diff), 32'(ed));
        chk({tag, "_bout"}, 32'(sif.bout), 32'(ebo));
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(sif.ovf), 32'(eov));
`else
        if (eov === 1'bx) $display("note: undefined ovf expectation for %s", tag);
`endif
        @(negedge clk);
        sif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        sif.out_ready = 1'b0;
        chk({tag, "_ovld_fall"}, 32'(sif.out_valid), 32'd0);
        chk({tag, "_iready_rise"}, 32'(sif.in_ready), 32'd1);
        chk({tag, "_diff_kept"}, 32'(sif.diff), 32'(ed));
    endtask

    vec_t tbl[5];

    initial begin
        logic [W-1:0] ra, rb, md;
        logic         rbin, mbo, mov;

        tbl[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, d: 8'h02, bo: 1'b0, ov: 1'b0};
        tbl[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, d: 8'hFE, bo: 1'b1, ov: 1'b0};
        tbl[2] = '{a: 8'h00, b: 8'h00, bin: 1'b1, d: 8'hFF, bo: 1'b1, ov: 1'b0};
        tbl[3] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bo: 1'b0, ov: 1'b1};
        tbl[4] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, d: 8'hFF, bo: 1'b1, ov: 1'b0};

        sif.in_valid = 1'b0;
        sif.a = '0;
        sif.b = '0;
        sif.bin = 1'b0;
        sif.out_ready = 1'b0;
        rst_n = 1'b0;

        #12;
        chk("rst_in_ready", 32'(sif.in_ready), 32'd0);
        chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_diff", 32'(sif.diff), 32'd0);
        chk("rst_bout", 32'(sif.bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", 32'(sif.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", 32'(sif.in_ready), 32'd1);

        for (int i = 0; i < 5; i++)
            do_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin,
                  tbl[i].d, tbl[i].bo, tbl[i].ov, (i == 1) ? 5 : 0);

        // Abort mid-RUN with an asynchronous reset
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.a = 8'hFF;
        sif.b = 8'h01;
        sif.bin = 1'b0;
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(sif.out_valid), 32'd0);
        chk("abort_diff", 32'(sif.diff), 32'd0);
        chk("abort_bout", 32'(sif.bout), 32'd0);
        chk("abort_in_ready", 32'(sif.in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_rel_in_ready", 32'(sif.in_ready), 32'd1);
        do_op("post_abort", 8'hA0, 8'h0A, 1'b0, 8'h96, 1'b0, 1'b0, 1);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rbin = 1'($urandom_range(0, 1));
            model(ra, rb, rbin, md, mbo, mov);
            do_op($sformatf("rnd%0d", i), ra, rb, rbin, md, mbo, mov, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
